// File: rtl/mux2_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the downstream sink.
interface mux2_arbiter_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              sel;

  // Arbiter side.
  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, sel
  );

  // Requesters plus sink side.
  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, sel
  );

endinterface

// File: rtl/mux2_arbiter.sv
// Two-requester burst arbiter feeding a single registered output slot.
// A requester keeps the grant for up to MAX_BURST transfers while the other
// one is waiting; ties from idle go to whoever was not served last.
module mux2_arbiter #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  mux2_arbiter_if.slave    bus_io
);

  typedef enum logic [1:0] {StIdle, StGrantA, StGrantB} state_e;

  localparam logic [3:0] LastBeat = 4'(MAX_BURST - 1);

  state_e            state_q, state_d;
  logic              last_srv_q, last_srv_d;  // 0 = A, 1 = B
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              sel_q, sel_d;

  logic slot_free;
  logic a_ready, b_ready;
  logic xfer_a, xfer_b;

  // Handshake decode; readies are forced low while reset is asserted.
  always_comb begin
    slot_free = !out_valid_q || bus_io.out_ready;
    a_ready   = !rst && (state_q == StGrantA) && slot_free;
    b_ready   = !rst && (state_q == StGrantB) && slot_free;
    xfer_a    = bus_io.a_valid && a_ready;
    xfer_b    = bus_io.b_valid && b_ready;
    // Select follows the grant and holds its last value while idle.
    sel_d = sel_q;
    if (state_q == StGrantA) sel_d = 1'b0;
    if (state_q == StGrantB) sel_d = 1'b1;
  end

  assign bus_io.a_ready   = a_ready;
  assign bus_io.b_ready   = b_ready;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.sel       = rst ? 1'b0 : sel_d;

  // Output slot: load on a transfer, drain when the sink takes it, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (xfer_a) begin
      out_valid_d = 1'b1;
      out_data_d  = bus_io.a_data;
    end else if (xfer_b) begin
      out_valid_d = 1'b1;
      out_data_d  = bus_io.b_data;
    end else if (bus_io.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Grant FSM with burst counting and last-served tracking.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    last_srv_d  = last_srv_q;
    case (state_q)
      StIdle: begin
        burst_cnt_d = '0;
        if (bus_io.a_valid && bus_io.b_valid) begin
          state_d = last_srv_q ? StGrantA : StGrantB;
        end else if (bus_io.a_valid) begin
          state_d = StGrantA;
        end else if (bus_io.b_valid) begin
          state_d = StGrantB;
        end
      end
      StGrantA: begin
        if (!bus_io.a_valid) begin
          state_d     = bus_io.b_valid ? StGrantB : StIdle;
          burst_cnt_d = '0;
        end else if (xfer_a) begin
          last_srv_d = 1'b0;
          if (burst_cnt_q == LastBeat) begin
            burst_cnt_d = '0;
            if (bus_io.b_valid) state_d = StGrantB;
          end else begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end
        end
      end
      StGrantB: begin
        if (!bus_io.b_valid) begin
          state_d     = bus_io.a_valid ? StGrantA : StIdle;
          burst_cnt_d = '0;
        end else if (xfer_b) begin
          last_srv_d = 1'b1;
          if (burst_cnt_q == LastBeat) begin
            burst_cnt_d = '0;
            if (bus_io.a_valid) state_d = StGrantA;
          end else begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d     = StIdle;
        burst_cnt_d = '0;
      end
    endcase
  end

  // State registers; reset wins over everything and drops any held output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_srv_q  <= 1'b1;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sel_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_srv_q  <= last_srv_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sel_q       <= sel_d;
    end
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Bench for mux2_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of grant ownership and run length.
module tb_mux2_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux2_arbiter_if #(.DATA_W(DW)) bus ();

  mux2_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: owner -1 none, 0 A, 1 B; run = transfers in the current burst.
  int          m_gnt, m_run, m_last;
  logic        m_ov, m_sel;
  logic [7:0]  m_od;
  logic        ea, eb, esel;

  task automatic model_reset();
    m_gnt = -1; m_run = 0; m_last = 1;
    m_ov = 1'b0; m_od = 8'h00; m_sel = 1'b0;
  endtask

  task automatic model_eval();
    logic free;
    free = !m_ov || bus.out_ready;
    ea   = !rst && (m_gnt == 0) && free;
    eb   = !rst && (m_gnt == 1) && free;
    esel = rst ? 1'b0 : ((m_gnt < 0) ? m_sel : (m_gnt == 1));
  endtask

  task automatic model_advance();
    logic xa, xb, mine, other;
    if (rst) begin
      model_reset();
    end else begin
      xa = bus.a_valid && ea;
      xb = bus.b_valid && eb;
      if (xa) begin m_ov = 1'b1; m_od = bus.a_data; end
      else if (xb) begin m_ov = 1'b1; m_od = bus.b_data; end
      else if (bus.out_ready) m_ov = 1'b0;
      m_sel = esel;
      if (m_gnt < 0) begin
        m_run = 0;
        if (bus.a_valid && bus.b_valid) m_gnt = (m_last == 1) ? 0 : 1;
        else if (bus.a_valid) m_gnt = 0;
        else if (bus.b_valid) m_gnt = 1;
      end else begin
        mine  = (m_gnt == 0) ? bus.a_valid : bus.b_valid;
        other = (m_gnt == 0) ? bus.b_valid : bus.a_valid;
        if (!mine) begin
          m_gnt = other ? 1 - m_gnt : -1;
          m_run = 0;
        end else if (xa || xb) begin
          m_last = m_gnt;
          m_run++;
          if (m_run == int'(MB)) begin
            m_run = 0;
            if (other) m_gnt = 1 - m_gnt;
          end
        end
      end
    end
  endtask

  task automatic drive(input logic av, input logic [7:0] ad, input logic bv,
                       input logic [7:0] bd, input logic ordy);
    bus.a_valid = av; bus.a_data = ad;
    bus.b_valid = bv; bus.b_data = bd;
    bus.out_ready = ordy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 8'h5a, 1'b1, 8'ha5, 1'b1);
    @(negedge clk);
    model_reset();
    for (int c = 0; c < 2; c++) begin
      #1 model_eval();
      n_cmp++;
      if ({bus.a_ready, bus.b_ready, bus.out_valid, bus.sel} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset c%0d: got rdy=%b%b ov=%b sel=%b need 0000", c,
                 bus.a_ready, bus.b_ready, bus.out_valid, bus.sel);
      end
      n_cmp++;
      if ({bus.a_ready, bus.b_ready, bus.out_valid, bus.out_data, bus.sel} !==
          {ea, eb, m_ov, m_od, esel}) begin
        n_fail++;
        $display("FAIL reset_model c%0d: got %b%b%b %h %b need %b%b%b %h %b", c,
                 bus.a_ready, bus.b_ready, bus.out_valid, bus.out_data, bus.sel,
                 ea, eb, m_ov, m_od, esel);
      end
      model_advance();
      @(negedge clk);
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_single();
    int idx = 0;
    logic [7:0] want;
    for (int c = 0; c < 9; c++) begin
      drive(idx < 6, 8'(8'h11 * (idx + 1)), 1'b0, 8'h00, 1'b1);
      #1 model_eval();
      n_cmp++;
      if ({bus.a_ready, bus.b_ready, bus.out_valid, bus.out_data, bus.sel} !==
          {ea, eb, m_ov, m_od, esel}) begin
        n_fail++;
        $display("FAIL single_model c%0d: got %b%b%b %h %b need %b%b%b %h %b", c,
                 bus.a_ready, bus.b_ready, bus.out_valid, bus.out_data, bus.sel,
                 ea, eb, m_ov, m_od, esel);
      end
      if (c <= 6) begin
        n_cmp++;
        if (bus.a_ready !== (c >= 1)) begin
          n_fail++;
          $display("FAIL single_ready c%0d: got %b need %b", c, bus.a_ready, c >= 1);
        end
      end
      if (c >= 2 && c <= 7) begin
        want = 8'(8'h11 * (c - 1));
        n_cmp++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, want}) begin
          n_fail++;
          $display("FAIL single_data c%0d: got ov=%b %h need 1 %h", c,
                   bus.out_valid, bus.out_data, want);
        end
      end
      if (ea && bus.a_valid) idx++;
      model_advance();
      @(negedge clk);
    end
  endtask

  task automatic test_tie();
    for (int c = 0; c < 4; c++) begin
      drive(c < 2, 8'h3c, c < 2, 8'hc3, 1'b1);
      #1 model_eval();
      n_cmp++;
      if ({bus.a_ready, bus.b_ready, bus.out_valid, bus.out_data, bus.sel} !==
          {ea, eb, m_ov, m_od, esel}) begin
        n_fail++;
        $display("FAIL tie_model c%0d: got %b%b%b %h %b need %b%b%b %h %b", c,
                 bus.a_ready, bus.b_ready, bus.out_valid, bus.out_data, bus.sel,
                 ea, eb, m_ov, m_od, esel);
      end
      if (c == 1) begin
        n_cmp++;
        if ({bus.a_ready, bus.b_ready, bus.sel} !== 3'b011) begin
          n_fail++;
          $display("FAIL tie_grant_b: got rdy=%b%b sel=%b need 01 1",
                   bus.a_ready, bus.b_ready, bus.sel);
        end
      end
      model_advance();
      @(negedge clk);
    end
  endtask

  task automatic test_contention();
    int na = 0, nb = 0, who;
    for (int c = 0; c < 20; c++) begin
      drive(c < 17, 8'(8'ha0 + na), c < 17, 8'(8'hb0 + nb), 1'b1);
      #1 model_eval();
      n_cmp++;
      if ({bus.a_ready, bus.b_ready, bus.out_valid, bus.out_data, bus.sel} !==
          {ea, eb, m_ov, m_od, esel}) begin
        n_fail++;
        $display("FAIL cont_model c%0d: got %b%b%b %h %b need %b%b%b %h %b", c,
                 bus.a_ready, bus.b_ready, bus.out_valid, bus.out_data, bus.sel,
                 ea, eb, m_ov, m_od, esel);
      end
      if (c >= 1 && c <= 16) begin
        who = ((c - 1) / 4) % 2;
        n_cmp++;
        if ({bus.a_ready, bus.b_ready, bus.sel} !== {who == 0, who == 1, who == 1}) begin
          n_fail++;
          $display("FAIL cont_alternate c%0d: got rdy=%b%b sel=%b need owner %0d", c,
                   bus.a_ready, bus.b_ready, bus.sel, who);
        end
      end
      if (ea && bus.a_valid) na++;
      if (eb && bus.b_valid) nb++;
      model_advance();
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    for (int c = 0; c < 11; c++) begin
      drive(idx < 4, 8'(8'h11 * (idx + 1)), 1'b0, 8'h00, !(c >= 3 && c <= 5));
      #1 model_eval();
      n_cmp++;
      if ({bus.a_ready, bus.b_ready, bus.out_valid, bus.out_data, bus.sel} !==
          {ea, eb, m_ov, m_od, esel}) begin
        n_fail++;
        $display("FAIL bp_model c%0d: got %b%b%b %h %b need %b%b%b %h %b", c,
                 bus.a_ready, bus.b_ready, bus.out_valid, bus.out_data, bus.sel,
                 ea, eb, m_ov, m_od, esel);
      end
      if (c >= 3 && c <= 5) begin
        n_cmp++;
        if ({bus.out_valid, bus.out_data, bus.a_ready, dut.burst_cnt_q} !==
            {1'b1, 8'h22, 1'b0, 4'd2}) begin
          n_fail++;
          $display("FAIL bp_hold c%0d: got ov=%b od=%h a_rdy=%b cnt=%0d need 1 22 0 2",
                   c, bus.out_valid, bus.out_data, bus.a_ready, dut.burst_cnt_q);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (bus.a_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_resume: got a_ready=%b need 1", bus.a_ready);
        end
      end
      if (ea && bus.a_valid) idx++;
      model_advance();
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midburst();
    for (int c = 0; c < 8; c++) begin
      rst = (c == 3);
      drive(c < 6, 8'(8'h50 + c), c >= 4 && c < 6, 8'(8'h60 + c), 1'b1);
      #1 model_eval();
      n_cmp++;
      if ({bus.a_ready, bus.b_ready, bus.out_valid, bus.out_data, bus.sel} !==
          {ea, eb, m_ov, m_od, esel}) begin
        n_fail++;
        $display("FAIL rstmid_model c%0d: got %b%b%b %h %b need %b%b%b %h %b", c,
                 bus.a_ready, bus.b_ready, bus.out_valid, bus.out_data, bus.sel,
                 ea, eb, m_ov, m_od, esel);
      end
      if (c == 3) begin
        n_cmp++;
        if ({bus.a_ready, bus.b_ready, dut.burst_cnt_q} !== {2'b00, 4'd2}) begin
          n_fail++;
          $display("FAIL rstmid_in_reset: got rdy=%b%b cnt=%0d need 00 2",
                   bus.a_ready, bus.b_ready, dut.burst_cnt_q);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if ({bus.out_valid, bus.a_ready, bus.b_ready} !== 3'b000) begin
          n_fail++;
          $display("FAIL rstmid_idle: got ov=%b rdy=%b%b need 0 00",
                   bus.out_valid, bus.a_ready, bus.b_ready);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if ({bus.a_ready, bus.b_ready, bus.sel} !== 3'b100) begin
          n_fail++;
          $display("FAIL rstmid_tie_a: got rdy=%b%b sel=%b need 10 0",
                   bus.a_ready, bus.b_ready, bus.sel);
        end
      end
      model_advance();
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(99) == 0);
      drive($urandom_range(9) < 7, 8'($urandom), $urandom_range(9) < 7, 8'($urandom),
            $urandom_range(3) != 0);
      #1 model_eval();
      n_cmp++;
      if ({bus.a_ready, bus.b_ready, bus.out_valid, bus.out_data, bus.sel} !==
          {ea, eb, m_ov, m_od, esel}) begin
        n_fail++;
        $display("FAIL random_model c%0d: got %b%b%b %h %b need %b%b%b %h %b", c,
                 bus.a_ready, bus.b_ready, bus.out_valid, bus.out_data, bus.sel,
                 ea, eb, m_ov, m_od, esel);
      end
      model_advance();
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_contention();
    test_backpressure();
    test_reset_midburst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
